// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one ram512x8 port between instruction fetch (port 0) and data access (port 1)
// Ports:
//   Clk, reset                 clock, synchronous active-high reset
//   reqN/rwN/addrN/sizeN/wdataN requester N command, held until doneN (rw 1=read)
//   doneN/errN                 one-cycle completion pulse, error valid with done
//   rdata                      last successfully read data
//   busy                       arbiter not idle
//   ramMFA/ramRW/ramAddress/ramDataIn/ramDataSize  registered RAM command lines
//   ramDataOut/ramMFC          RAM read data and function-complete handshake
module ram_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ramMFA,
    output logic              ramRW,
    output logic [ADDR_W-1:0] ramAddress,
    output logic [DATA_W-1:0] ramDataIn,
    output logic [1:0]        ramDataSize,
    input  logic [DATA_W-1:0] ramDataOut,
    input  logic              ramMFC
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic              last_gnt, gnt, win, w_rw, legal, timeout;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_size;
    logic [DATA_W-1:0] w_wdata;
    always_comb begin
        win     = (req0 && req1) ? ~last_gnt : req1;
        w_rw    = win ? rw1 : rw0;
        w_addr  = win ? addr1 : addr0;
        w_size  = win ? size1 : size0;
        w_wdata = win ? wdata1 : wdata0;
        legal   = (w_size == 2'b00) || (w_size == 2'b01 && !w_addr[0]) ||
                  (w_size == 2'b10 && w_addr[1:0] == 2'b00);
        timeout = count == CW'(TIMEOUT - 1);
    end
    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            last_gnt    <= 1'b1;
            gnt         <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b0;
            ramMFA      <= 1'b0;
            ramRW       <= 1'b0;
            ramAddress  <= '0;
            ramDataIn   <= '0;
            ramDataSize <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    gnt      <= win;
                    last_gnt <= win;
                    count    <= '0;
                    busy     <= 1'b1;
                    if (legal) begin
                        state       <= ACCESS;
                        ramMFA      <= 1'b1;
                        ramRW       <= w_rw;
                        ramAddress  <= w_addr;
                        ramDataSize <= w_size;
                        ramDataIn   <= w_wdata;
                    end else begin
                        // illegal request completes with error without touching the RAM
                        state <= DONE;
                        done0 <= !win;
                        done1 <= win;
                        err0  <= !win;
                        err1  <= win;
                    end
                end
                ACCESS: if (ramMFC || timeout) begin
                    // MFC on the last allowed cycle still counts as success
                    state  <= DONE;
                    ramMFA <= 1'b0;
                    count  <= '0;
                    done0  <= !gnt;
                    done1  <= gnt;
                    err0   <= !ramMFC && !gnt;
                    err1   <= !ramMFC && gnt;
                    if (ramMFC && ramRW) rdata <= ramDataOut;
                end else begin
                    count <= count + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    ramMFA <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for ram_port_arbiter with a behavioural RAM responder
module tb_ram_port_arbiter;
    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } exp_t;
    logic        Clk = 1'b0, reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
    logic [8:0]  addr0 = '0, addr1 = '0;
    logic [1:0]  size0 = '0, size1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1, busy, ramMFA, ramRW, ramMFC;
    logic [31:0] rdata, ramDataIn, ramDataOut;
    logic [8:0]  ramAddress;
    logic [1:0]  ramDataSize;
    exp_t        sb[$];
    int          errors = 0, checks = 0;
    int          mfc_at = -1, mfa_cnt = 0;
    bit          mfc_force = 1'b0;
    logic [31:0] ram_data = '0, exp_rdata = '0;
    bit          line_chk = 1'b0, line_rw = 1'b0;
    logic [8:0]  line_addr = '0;
    logic [1:0]  line_size = '0;
    logic [31:0] line_wdata = '0;
    int          mfa, lat;

    ram_port_arbiter dut (
        .Clk(Clk), .reset(reset),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .size0(size0), .size1(size1),
        .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata(rdata), .busy(busy),
        .ramMFA(ramMFA), .ramRW(ramRW), .ramAddress(ramAddress),
        .ramDataIn(ramDataIn), .ramDataSize(ramDataSize),
        .ramDataOut(ramDataOut), .ramMFC(ramMFC)
    );

    always #5 Clk = ~Clk;

    // RAM responder: raises MFC in the mfc_at-th cycle of ramMFA; data is garbage unless MFC
    initial begin
        ramMFC = 1'b0;
        ramDataOut = '0;
        forever begin
            @(negedge Clk);
            mfa_cnt = ramMFA ? mfa_cnt + 1 : 0;
            ramMFC = mfc_force || (mfc_at > 0 && mfa_cnt == mfc_at);
            ramDataOut = ramMFC ? ram_data : ~ram_data;
        end
    end

    task automatic issue(input bit p, input bit rw, input logic [8:0] a, input logic [1:0] s,
                         input logic [31:0] wd, input bit e);
        exp_t x;
        if (p) begin
            req1 = 1'b1; rw1 = rw; addr1 = a; size1 = s; wdata1 = wd;
        end else begin
            req0 = 1'b1; rw0 = rw; addr0 = a; size0 = s; wdata0 = wd;
        end
        if (rw && !e) exp_rdata = ram_data;
        x.port = p;
        x.err = e;
        x.rdata = exp_rdata;
        sb.push_back(x);
    endtask

    task automatic set_lines(input bit rw, input logic [8:0] a, input logic [1:0] s, input logic [31:0] wd);
        line_chk = 1'b1; line_rw = rw; line_addr = a; line_size = s; line_wdata = wd;
    endtask

    task automatic wait_done(input int budget, input bit drop, output int n_mfa, output int n_lat);
        exp_t x;
        int bad = 0;
        logic [3:0] want;
        n_mfa = 0;
        n_lat = 0;
        while (1) begin
            @(negedge Clk);
            n_lat++;
            if (ramMFA) begin
                n_mfa++;
                if (line_chk && {ramRW, ramAddress, ramDataSize, ramDataIn} !==
                    {line_rw, line_addr, line_size, line_wdata}) bad++;
            end
            if (done0 || done1) break;
            if (n_lat >= budget) begin
                checks++;
                errors++;
                $display("FAIL wait_done: no done pulse within %0d cycles", budget);
                req0 = 1'b0;
                req1 = 1'b0;
                return;
            end
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: done1/done0=%b%b with empty scoreboard", done1, done0);
        end else begin
            x = sb.pop_front();
            want = x.port ? {2'b10, x.err, 1'b0} : {2'b01, 1'b0, x.err};
            if ({done1, done0, err1, err0} !== want || rdata !== x.rdata) begin
                errors++;
                $display("FAIL done_port%0d: got done1,done0,err1,err0=%b rdata=%h, want %b rdata=%h",
                         x.port, {done1, done0, err1, err0}, rdata, want, x.rdata);
            end
        end
        if (line_chk) begin
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL ram_lines: %0d cycles with wrong RAM lines, want 0", bad);
            end
        end
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        @(negedge Clk);
        checks++;
        if ({done1, done0} !== 2'b00) begin
            errors++;
            $display("FAIL done_pulse: done1,done0=%b one cycle later, want 00", {done1, done0});
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({done0, done1, err0, err1, rdata, busy, ramMFA, ramRW, ramAddress, ramDataIn, ramDataSize} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b mfa=%b rdata=%h addr=%h, want all zero",
                     busy, ramMFA, rdata, ramAddress);
        end
        reset = 1'b0;
        exp_rdata = '0;
        sb.delete();
    endtask

    task automatic test_read;
        ram_data = 32'hDEADBEEF;
        mfc_at = 2;
        set_lines(1'b1, 9'h010, 2'b10, 32'h0);
        issue(0, 1'b1, 9'h010, 2'b10, 32'h0, 0);
        wait_done(10, 1, mfa, lat);
        check_int("read_latency", lat, 3);
        check_int("read_mfa_cycles", mfa, 2);
        check_int("read_busy_after", int'(busy), 0);
    endtask

    task automatic test_fairness;
        test_reset();
        ram_data = 32'h12345678;
        mfc_at = 1;
        line_chk = 1'b0;
        issue(0, 1'b1, 9'h020, 2'b10, 32'h0, 0);
        issue(1, 1'b1, 9'h040, 2'b10, 32'h0, 0);
        issue(0, 1'b1, 9'h020, 2'b10, 32'h0, 0);
        wait_done(10, 0, mfa, lat);
        check_int("fair_lat0", lat, 2);
        wait_done(10, 0, mfa, lat);
        check_int("fair_lat1", lat, 2);
        wait_done(10, 1, mfa, lat);
        check_int("fair_lat2", lat, 2);
    endtask

    task automatic test_align;
        mfc_at = 3;
        line_chk = 1'b0;
        issue(1, 1'b0, 9'h0C2, 2'b10, 32'hA5A5A5A5, 1);
        wait_done(10, 1, mfa, lat);
        check_int("misaligned_word_mfa", mfa, 0);
        check_int("misaligned_word_lat", lat, 1);
        issue(0, 1'b1, 9'h000, 2'b11, 32'h0, 1);
        wait_done(10, 1, mfa, lat);
        check_int("illegal_size_mfa", mfa, 0);
        set_lines(1'b0, 9'h0C2, 2'b01, 32'hCAFEF00D);
        issue(1, 1'b0, 9'h0C2, 2'b01, 32'hCAFEF00D, 0);
        wait_done(10, 1, mfa, lat);
        check_int("half_write_mfa", mfa, 3);
        check_int("half_write_lat", lat, 4);
    endtask

    task automatic test_timeout;
        mfc_at = -1;
        ram_data = 32'h0F0F0F0F;
        set_lines(1'b1, 9'h100, 2'b00, 32'h0);
        issue(1, 1'b1, 9'h100, 2'b00, 32'h0, 1);
        wait_done(40, 1, mfa, lat);
        check_int("timeout_mfa", mfa, 16);
        check_int("timeout_lat", lat, 17);
        mfc_at = 1;
        ram_data = 32'h600DCAFE;
        set_lines(1'b1, 9'h101, 2'b00, 32'h0);
        issue(0, 1'b1, 9'h101, 2'b00, 32'h0, 0);
        wait_done(10, 1, mfa, lat);
        check_int("after_timeout_lat", lat, 2);
    endtask

    task automatic test_reset_mid;
        mfc_at = -1;
        req0 = 1'b1; rw0 = 1'b1; addr0 = 9'h004; size0 = 2'b10;
        repeat (3) @(negedge Clk);
        check_int("mid_mfa_active", int'(ramMFA && busy), 1);
        reset = 1'b1;
        req0 = 1'b0;
        @(negedge Clk);
        checks++;
        if ({ramMFA, busy, done0, done1, err0, err1} !== 6'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got mfa,busy,done,err=%b rdata=%h, want 0 and 0",
                     {ramMFA, busy, done0, done1, err0, err1}, rdata);
        end
        reset = 1'b0;
        exp_rdata = '0;
        mfc_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if ({ramMFA, busy, done0, done1} !== 4'b0) begin
                errors++;
                $display("FAIL stray_mfc: got mfa,busy,done0,done1=%b, want 0000",
                         {ramMFA, busy, done0, done1});
            end
        end
        mfc_force = 1'b0;
        @(negedge Clk);
        mfc_at = 1;
        ram_data = 32'h13579BDF;
        set_lines(1'b1, 9'h008, 2'b10, 32'h0);
        issue(1, 1'b1, 9'h008, 2'b10, 32'h0, 0);
        wait_done(10, 1, mfa, lat);
        check_int("after_reset_lat", lat, 2);
    endtask

    task automatic test_mfc_last;
        mfc_at = 16;
        ram_data = 32'h0BADF00D;
        set_lines(1'b1, 9'h1FC, 2'b10, 32'h0);
        issue(0, 1'b1, 9'h1FC, 2'b10, 32'h0, 0);
        wait_done(40, 1, mfa, lat);
        check_int("mfc_last_mfa", mfa, 16);
        check_int("mfc_last_lat", lat, 17);
    endtask

    initial begin
        test_reset();
        test_read();
        test_fairness();
        test_align();
        test_timeout();
        test_reset_mid();
        test_mfc_last();
        check_int("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
